des_key_schedule: RTL and testbench

- Generates the sixteen 48-bit DES round keys, one per handshake, from a 64-bit key.
- Sits directly upstream of DES_round_wrapper and drives its round_key input.
- Supports encrypt order (K1..K16) and decrypt order (K16..K1).
- Triple-DES control instantiates one schedule per DES stage, or reloads a single schedule per stage.

---
 rtl/des_pkg.sv | 58 +++++
 rtl/des_pc2_perm.sv | 18 +
 rtl/des_key_schedule.sv | 111 +++++++++++
 tb/tb_des_key_schedule.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule definitions.
//   PC1_TAB / PC2_TAB : DES permuted-choice tables (DES bit numbering, 1 = MSB)
//   SHIFT / DSHIFT    : per-round C/D rotation amounts for encrypt / decrypt order
//   ks_state_t        : key-schedule FSM states
//   rotl28 / rotr28   : 28-bit half rotations
//   pc1               : PC-1 permutation, 64 -> 56
package des_pkg;

   localparam int unsigned NUM_ROUNDS = 16;

   localparam int unsigned PC1_TAB [56] = '{
      57, 49, 41, 33, 25, 17,  9,
       1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27,
      19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,
       7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29,
      21, 13,  5, 28, 20, 12,  4
   };

   localparam int unsigned PC2_TAB [48] = '{
      14, 17, 11, 24,  1,  5,
       3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8,
      16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55,
      30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53,
      46, 42, 50, 36, 29, 32
   };

   // SHIFT[0] is applied at load; SHIFT[r+1] on the handshake of round r.
   localparam int unsigned SHIFT  [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
   // Decrypt starts from the unrotated PC-1 value (K16), hence DSHIFT[0] = 0.
   localparam int unsigned DSHIFT [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   typedef enum logic {IDLE, ROUND} ks_state_t;

   // n must be 0..2; a zero shift yields x unchanged.
   function automatic logic [27:0] rotl28(input logic [27:0] x, input int unsigned n);
      return (x << n) | (x >> (28 - n));
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input int unsigned n);
      return (x >> n) | (x << (28 - n));
   endfunction

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
      end
      return r;
   endfunction

endpackage

// File: rtl/des_pc2_perm.sv
// PC-2 permutation (combinational, 56 -> 48).
//   i_cd  : C||D register, DES bit 1 = i_cd[55]
//   o_key : round key, DES bit 1 = o_key[47]
module des_pc2_perm
   import des_pkg::*;
(
   input  logic [55:0] i_cd,
   output logic [47:0] o_key
);

   always_comb begin
      o_key = '0;
      for (int b = 0; b < 48; b++) begin
         o_key[6'(47 - b)] = i_cd[6'(56 - PC2_TAB[b])];
      end
   end

endmodule

// File: rtl/des_key_schedule.sv
// DES key schedule: issues the sixteen 48-bit round keys, one per valid/ready
// handshake, in encrypt (K1..K16) or decrypt (K16..K1) order.
//   clk, rst            : clock, synchronous active-high reset
//   key_load, key_in    : start a schedule for a 64-bit key (accepted only when idle)
//   decrypt             : sampled with key_load, selects reverse key order
//   round_ready         : downstream accepts the current key
//   round_valid         : round_key / round_num are valid
//   round_key           : PC-2 of the current C/D register
//   round_num           : issue index 0..15
//   last_round          : valid key with round_num == 15
//   busy                : a schedule is in progress
module des_key_schedule
   import des_pkg::*;
#(
   parameter int unsigned NUM_ROUNDS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_load,
   input  logic [63:0] key_in,
   input  logic        decrypt,
   input  logic        round_ready,
   output logic        round_valid,
   output logic [47:0] round_key,
   output logic [3:0]  round_num,
   output logic        last_round,
   output logic        busy
);

   ks_state_t   r_state;
   logic [55:0] r_cd;
   logic [3:0]  r_round_num;
   logic        r_dec;
   logic        r_round_valid;

   logic [55:0] w_pc1;
   logic [55:0] w_load_cd;
   logic [3:0]  w_next_idx;
   logic [55:0] w_next_cd;
   logic        w_fire;
   logic        w_last;

   assign w_pc1     = pc1(key_in);
   assign w_load_cd = decrypt ? w_pc1
                              : {rotl28(w_pc1[55:28], 1), rotl28(w_pc1[27:0], 1)};

   // Wraps to 0 on the last round; unused there because the FSM returns to IDLE.
   assign w_next_idx = r_round_num + 4'd1;

   always_comb begin
      w_next_cd = r_cd;
      if (r_dec) begin
         w_next_cd = {rotr28(r_cd[55:28], DSHIFT[w_next_idx]),
                      rotr28(r_cd[27:0],  DSHIFT[w_next_idx])};
      end else begin
         w_next_cd = {rotl28(r_cd[55:28], SHIFT[w_next_idx]),
                      rotl28(r_cd[27:0],  SHIFT[w_next_idx])};
      end
   end

   assign w_fire = r_round_valid && round_ready;
   assign w_last = r_round_num == 4'(NUM_ROUNDS - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= IDLE;
         r_cd          <= '0;
         r_round_num   <= '0;
         r_dec         <= 1'b0;
         r_round_valid <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (key_load) begin
                  r_cd          <= w_load_cd;
                  r_dec         <= decrypt;
                  r_round_num   <= '0;
                  r_round_valid <= 1'b1;
                  r_state       <= ROUND;
               end
            end
            ROUND: begin
               if (w_fire) begin
                  if (w_last) begin
                     r_round_valid <= 1'b0;
                     r_state       <= IDLE;
                  end else begin
                     r_cd        <= w_next_cd;
                     r_round_num <= w_next_idx;
                  end
               end
            end
            default: begin
               r_round_valid <= 1'b0;
               r_state       <= IDLE;
            end
         endcase
      end
   end

   des_pc2_perm u_pc2 (
      .i_cd  (r_cd),
      .o_key (round_key)
   );

   assign round_valid = r_round_valid;
   assign round_num   = r_round_num;
   assign last_round  = r_round_valid && w_last;
   assign busy        = r_state != IDLE;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule. The reference model derives each
// key K_i directly from the cumulative rotation of the PC-1 halves.
module tb_des_key_schedule;

   localparam logic [63:0] KNOWN_KEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] KNOWN_K1  = 48'h1B02EFFC7072;
   localparam logic [47:0] KNOWN_K16 = 48'hCB3D8B0E17F5;

   int pc1_t [56] = '{
      57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
      10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
      63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
      14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
   };
   int pc2_t [48] = '{
      14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
      23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
      41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
      44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
   };
   // Standard DES left-shift schedule for K1..K16.
   int shifts [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

   logic        clk = 1'b0;
   logic        rst;
   logic        key_load;
   logic [63:0] key_in;
   logic        decrypt;
   logic        round_ready;
   logic        round_valid;
   logic [47:0] round_key;
   logic [3:0]  round_num;
   logic        last_round;
   logic        busy;

   logic [47:0] exp_keys [16];
   logic [47:0] enc_keys [16];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   des_key_schedule #(.NUM_ROUNDS(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .key_load    (key_load),
      .key_in      (key_in),
      .decrypt     (decrypt),
      .round_ready (round_ready),
      .round_valid (round_valid),
      .round_key   (round_key),
      .round_num   (round_num),
      .last_round  (last_round),
      .busy        (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // K_i = PC2(C0 <<< s_i, D0 <<< s_i), s_i = sum of the first i shifts.
   task automatic build_model(input logic [63:0] key, input bit dec);
      int c [28];
      int d [28];
      int cum;
      int p;
      logic [47:0] k;
      for (int n = 0; n < 28; n++) begin
         c[n] = int'(key[64 - pc1_t[n]]);
         d[n] = int'(key[64 - pc1_t[n + 28]]);
      end
      cum = 0;
      for (int i = 0; i < 16; i++) begin
         cum += shifts[i];
         k = '0;
         for (int b = 0; b < 48; b++) begin
            p = pc2_t[b];
            if (p <= 28) k[47 - b] = c[(p - 1 + cum) % 28][0];
            else         k[47 - b] = d[(p - 29 + cum) % 28][0];
         end
         enc_keys[i] = k;
      end
      for (int j = 0; j < 16; j++) begin
         exp_keys[j] = dec ? enc_keys[15 - j] : enc_keys[j];
      end
   endtask

   // One full schedule. Optional stall of 5 cycles at stall_at, random
   // backpressure, a key_load poke while busy, and a key_load on the final
   // handshake followed by the next-cycle reload.
   task automatic run_sched(input logic [63:0] key, input bit dec, input int stall_at,
                            input bit rnd_ready, input bit poke_busy, input bit final_load);
      int idx;
      int cyc;
      bit stalled;
      build_model(key, dec);
      key_in      = key;
      decrypt     = dec;
      key_load    = 1'b1;
      round_ready = 1'b1;
      tick();
      key_load = 1'b0;
      decrypt  = ~dec;
      chk("valid_after_load", {63'd0, round_valid}, 64'd1);
      idx     = 0;
      cyc     = 0;
      stalled = 1'b0;
      while (idx < 16 && cyc < 400) begin
         if (idx == stall_at && !stalled) begin
            round_ready = 1'b0;
            repeat (5) begin
               tick();
               chk("stall_key", {16'd0, round_key}, {16'd0, exp_keys[idx]});
               chk("stall_num", {60'd0, round_num}, 64'(idx));
               chk("stall_valid", {63'd0, round_valid}, 64'd1);
            end
            stalled = 1'b1;
         end
         round_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         key_load    = 1'b0;
         if (poke_busy && idx == 2) begin
            key_load = 1'b1;
            key_in   = 64'd0;
         end
         if (final_load && idx == 15) begin
            key_load = 1'b1;
            key_in   = key;
            decrypt  = dec;
            round_ready = 1'b1;
         end
         chk("valid", {63'd0, round_valid}, 64'd1);
         chk("num", {60'd0, round_num}, 64'(idx));
         chk("key", {16'd0, round_key}, {16'd0, exp_keys[idx]});
         chk("last", {63'd0, last_round}, (idx == 15) ? 64'd1 : 64'd0);
         chk("busy", {63'd0, busy}, 64'd1);
         tick();
         cyc++;
         if (round_ready) idx++;
      end
      round_ready = 1'b1;
      chk("done_in_budget", 64'(idx), 64'd16);
      chk("valid_after_end", {63'd0, round_valid}, 64'd0);
      chk("busy_after_end", {63'd0, busy}, 64'd0);
      if (final_load) begin
         // key_load is still high: accepted now that the block is idle.
         tick();
         key_load = 1'b0;
         chk("reload_valid", {63'd0, round_valid}, 64'd1);
         chk("reload_num", {60'd0, round_num}, 64'd0);
         chk("reload_key", {16'd0, round_key}, {16'd0, exp_keys[0]});
         repeat (16) tick();
         chk("reload_drained", {63'd0, busy}, 64'd0);
      end
      key_load = 1'b0;
      key_in   = key;
   endtask

   initial begin
      rst         = 1'b1;
      key_load    = 1'b0;
      key_in      = '0;
      decrypt     = 1'b0;
      round_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", {63'd0, round_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_last", {63'd0, last_round}, 64'd0);
      chk("rst_num", {60'd0, round_num}, 64'd0);
      chk("rst_key", {16'd0, round_key}, 64'd0);
      rst = 1'b0;
      tick();

      // Known-answer encrypt: first/last keys against published constants.
      build_model(KNOWN_KEY, 1'b0);
      chk("model_k1", {16'd0, exp_keys[0]}, {16'd0, KNOWN_K1});
      key_in = KNOWN_KEY; decrypt = 1'b0; key_load = 1'b1; round_ready = 1'b1;
      tick();
      key_load = 1'b0;
      chk("kat_enc_k1", {16'd0, round_key}, {16'd0, KNOWN_K1});
      repeat (15) tick();
      chk("kat_enc_num15", {60'd0, round_num}, 64'd15);
      chk("kat_enc_k16", {16'd0, round_key}, {16'd0, KNOWN_K16});
      chk("kat_enc_last", {63'd0, last_round}, 64'd1);
      tick();
      chk("kat_enc_idle", {63'd0, round_valid}, 64'd0);

      // Known-answer decrypt.
      key_in = KNOWN_KEY; decrypt = 1'b1; key_load = 1'b1;
      tick();
      key_load = 1'b0;
      chk("kat_dec_first", {16'd0, round_key}, {16'd0, KNOWN_K16});
      repeat (15) tick();
      chk("kat_dec_last", {16'd0, round_key}, {16'd0, KNOWN_K1});
      tick();

      // Full sequences with model comparison.
      run_sched(KNOWN_KEY, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      run_sched(KNOWN_KEY, 1'b1, -1, 1'b0, 1'b0, 1'b0);
      run_sched(64'h0, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      run_sched(64'h0, 1'b1, -1, 1'b0, 1'b0, 1'b0);
      run_sched({64{1'b1}}, 1'b0, -1, 1'b0, 1'b0, 1'b0);
      chk("ones_key", {16'd0, exp_keys[5]}, {16'd0, 48'hFFFFFFFFFFFF});
      run_sched({64{1'b1}}, 1'b1, -1, 1'b0, 1'b0, 1'b0);

      // Backpressure at round 3, key_load poke while busy, load on final handshake.
      run_sched(KNOWN_KEY, 1'b0, 3, 1'b0, 1'b0, 1'b0);
      run_sched(KNOWN_KEY, 1'b0, -1, 1'b0, 1'b1, 1'b0);
      run_sched(KNOWN_KEY, 1'b1, -1, 1'b0, 1'b0, 1'b1);

      // Random keys, order and backpressure.
      for (int t = 0; t < 8; t++) begin
         run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), -1, 1'b1, 1'b0, 1'b0);
      end

      // Reset mid-schedule at round 7, with key_load also asserted (rst wins).
      build_model(KNOWN_KEY, 1'b0);
      key_in = KNOWN_KEY; decrypt = 1'b0; key_load = 1'b1; round_ready = 1'b1;
      tick();
      key_load = 1'b0;
      repeat (7) tick();
      chk("pre_rst_num", {60'd0, round_num}, 64'd7);
      chk("pre_rst_key", {16'd0, round_key}, {16'd0, exp_keys[7]});
      rst = 1'b1; key_load = 1'b1;
      tick();
      rst = 1'b0; key_load = 1'b0;
      chk("mid_rst_valid", {63'd0, round_valid}, 64'd0);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      chk("mid_rst_num", {60'd0, round_num}, 64'd0);
      repeat (3) tick();
      chk("mid_rst_stays_idle", {63'd0, round_valid}, 64'd0);
      run_sched(KNOWN_KEY, 1'b0, -1, 1'b0, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
